hex_mult_sink: RTL and testbench
================================

# hex_mult_sink

Fabric-side consumer of the 32-bit `to_hex_export` PIO word written by the HPS.
- Detects a toggle-encoded command in the word and latches two 8-bit operands.
- Multiplies them with an 8-cycle shift-add engine.
- Drives six active-low seven-segment digits (HEX5..HEX0) with operands and product.
- Sits in the top level between `embedded_system` and the board HEX pins.

## Interface
Parameters:
- none; all field positions and widths are fixed in the package.

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- clk_clk  in  1  system clock, same as the `embedded_system` clock
- reset_reset  in  1  synchronous, active-high reset
- to_hex_export  in  32  PIO word:
  - [7:0] A, [15:8] B, [16] view, [30:17] ignored
  - [31] start toggle
- hex0..hex5  out  7 each  segments, active-low, bit0=a … bit6=g
- product  out  16  last completed A*B
- busy  out  1  high in MUL and DONE
- done  out  1  one-cycle pulse in DONE

## Operation
- Input stage: `to_hex_export` is registered into in_q every cycle. All logic uses in_q.
- tog_acc holds the last accepted value of bit 31. A command is pending whenever in_q[31] != tog_acc. The comparison is level-based.
- FSM, IDLE -> MUL -> DONE -> IDLE:
  - IDLE: if pending, capture a=in_q[7:0], b=in_q[15:8], set tog_acc=in_q[31], acc=0, cnt=0, go to MUL.
  - MUL: if b[0], acc += a<<cnt (17-bit add, no overflow possible). Then b>>=1 and cnt++. After the 8th step, product<=acc[15:0] and go to DONE.
  - DONE: done=1, go to IDLE.
- Toggle edges during MUL/DONE are not lost if bit 31 differs at return to IDLE. That command then starts with the operands current at that time. An even number of toggles while busy is absorbed.
- Display, live view = in_q[16]:
  - view 0: hex5:4 = captured a, hex3:0 = product.
  - view 1: hex5:4 = captured a, hex3:2 = captured b, hex1:0 = blank (7'h7F).
- Segment codes 0–F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex).

## Timing
- Reset values:
  - in_q=0, tog_acc=0, a=b=0, product=0, busy=0, done=0, state IDLE.
  - hex0..hex5 = 7'h7F.
  - Digit registers follow the display function from the first edge after reset deasserts.
- Latency: word written before edge N.
  - Edge N+1: in_q updated.
  - Edge N+2: accept, busy=1.
  - Edges N+3..N+10: 8 MUL steps; product valid after N+10.
  - Cycle N+10..N+11: done=1.
  - Edge N+11: hex updated, back to IDLE.
  - busy is high 9 cycles.
- Earliest next accept is one cycle after re-entering IDLE.
- View changes reach hex outputs 2 edges after the word change.
- Reset mid-MUL aborts the operation and clears product. If bit 31 = 1 after reset, a new command starts automatically because tog_acc = 0.

## Configuration
- HEX_LEADING_ZERO_BLANK_EN defined:
  - Leading-zero nibbles of product are shown as 7'h7F; hex0 is always lit.
  - The upper digit of each 2-digit operand field is blanked if zero.
- Undefined: every digit displays its value, including zeros.

## Structure
- Package hex_mult_sink_pkg holds:
  - FSM state enum {IDLE, MUL, DONE}.
  - Field constants: A_LSB=0, B_LSB=8, VIEW_BIT=16, TOG_BIT=31.
  - SEG_BLANK=7'h7F and the 16-entry segment table.
- One sub-module, hex7seg_decode: 4-bit nibble plus blank flag in, 7-bit active-low segments out, combinational. It is instantiated six times.

## Test plan
- Reset with word 0, macro off: hex* = 7F during reset. Two edges later hex0..hex3 = 40 and hex4/5 = 40; product=0, busy=0.
- A=0x0C, B=0x0D, bit31 0->1: busy high 9 cycles, a single done pulse, product=0x009C. hex1=10, hex0=46, hex3/hex2=40 (macro on: hex3/hex2=7F).
- A=B=0xFF, toggle: product=0xFE01; hex3=0E, hex2=06, hex1=40, hex0=79.
- Toggle during MUL with A=3, B=5: first result completes unchanged. The second command is accepted one cycle after IDLE and gives product=0x000F. Two toggles in MUL produce no second command.
- view 0->1 with a=0x12, b=0x34: after 2 edges, hex5=79, hex4=24, hex3=30, hex2=19, hex1=hex0=7F.
- Reset asserted at MUL step 4 with bit31=1 held: product=0 and busy=0. After release, a new command starts and product equals A*B of the current word.

Source files
------------

// File: rtl/hex_mult_sink_pkg.sv
// Shared definitions for hex_mult_sink: FSM states, PIO word field positions
// and the active-low seven-segment code table.
package hex_mult_sink_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    localparam int unsigned A_LSB    = 0;
    localparam int unsigned B_LSB    = 8;
    localparam int unsigned VIEW_BIT = 16;
    localparam int unsigned TOG_BIT  = 31;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index 0 is the rightmost entry; bit0 = segment a ... bit6 = segment g.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex_mult_sink_hex7seg_decode.sv
// Combinational nibble-to-segment decoder, active-low outputs, with a
// blank override that forces every segment off.
module hex7seg_decode
    import hex_mult_sink_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : SEG_TABLE[nibble];
    end

endmodule

// File: rtl/hex_mult_sink.sv
// HPS PIO consumer: toggle-triggered 8x8 shift-add multiplier driving six
// seven-segment digits. Optional macro HEX_LEADING_ZERO_BLANK_EN blanks leading zeros.
module hex_mult_sink
    import hex_mult_sink_pkg::*;
(
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [31:0] to_hex_export,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [15:0] product,
    output logic        busy,
    output logic        done
);

    state_t      state_q, state_d;
    logic [31:0] in_q;
    logic        tog_acc;
    logic [7:0]  a_q, b_q, mult_q;
    logic [16:0] acc_q, acc_next;
    logic [2:0]  cnt_q;
    logic        pending, accept;
    logic        view;
    logic        unused_in;

    logic [5:0][3:0] dig_nib;
    logic [5:0]      dig_blank;
    logic [5:0][6:0] dig_seg;

    assign unused_in = ^in_q[30:17];
    assign pending   = in_q[TOG_BIT] != tog_acc;
    assign view      = in_q[VIEW_BIT];
    assign acc_next  = acc_q + (mult_q[0] ? ({9'd0, a_q} << cnt_q) : 17'd0);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending) begin
                    accept  = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Captured b stays intact for the display; mult_q is the consumed copy.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            in_q    <= '0;
            tog_acc <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            mult_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            product <= '0;
        end else begin
            in_q <= to_hex_export;
            if (accept) begin
                a_q     <= in_q[A_LSB +: 8];
                b_q     <= in_q[B_LSB +: 8];
                mult_q  <= in_q[B_LSB +: 8];
                tog_acc <= in_q[TOG_BIT];
                acc_q   <= '0;
                cnt_q   <= '0;
            end else if (state_q == MUL) begin
                acc_q  <= acc_next;
                mult_q <= mult_q >> 1;
                cnt_q  <= cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    product <= acc_next[15:0];
                end
            end
        end
    end

    always_comb begin
        dig_nib    = '0;
        dig_blank  = '0;
        dig_nib[5] = a_q[7:4];
        dig_nib[4] = a_q[3:0];
        if (view) begin
            dig_nib[3]     = b_q[7:4];
            dig_nib[2]     = b_q[3:0];
            dig_blank[1:0] = 2'b11;
        end else begin
            dig_nib[3:0] = product;
        end
`ifdef HEX_LEADING_ZERO_BLANK_EN
        dig_blank[5] = (a_q[7:4] == 4'h0);
        if (view) begin
            dig_blank[3] = (b_q[7:4] == 4'h0);
        end else begin
            dig_blank[3] = (product[15:12] == 4'h0);
            dig_blank[2] = (product[15:8] == 8'h00);
            dig_blank[1] = (product[15:4] == 12'h000);
        end
`endif
    end

    for (genvar i = 0; i < 6; i++) begin : g_dig
        hex7seg_decode u_dec (
            .nibble (dig_nib[i]),
            .blank  (dig_blank[i]),
            .seg    (dig_seg[i])
        );
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            hex0 <= SEG_BLANK;
            hex1 <= SEG_BLANK;
            hex2 <= SEG_BLANK;
            hex3 <= SEG_BLANK;
            hex4 <= SEG_BLANK;
            hex5 <= SEG_BLANK;
        end else begin
            hex0 <= dig_seg[0];
            hex1 <= dig_seg[1];
            hex2 <= dig_seg[2];
            hex3 <= dig_seg[3];
            hex4 <= dig_seg[4];
            hex5 <= dig_seg[5];
        end
    end

endmodule

// File: tb/tb_hex_mult_sink.sv
// Randomised self-checking bench for hex_mult_sink against a cycle-level
// behavioural model built on plain multiplication and a phase counter.
module tb_hex_mult_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] word = '0;
    logic        tog = 1'b0;
    logic        view = 1'b0;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [15:0] product;
    logic        busy, done;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

`ifdef HEX_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    hex_mult_sink dut (
        .clk_clk       (clk),
        .reset_reset   (rst),
        .to_hex_export (word),
        .hex0          (hex0),
        .hex1          (hex1),
        .hex2          (hex2),
        .hex3          (hex3),
        .hex4          (hex4),
        .hex5          (hex5),
        .product       (product),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [6:0] digit(input int idx, input int a, input int b,
                                         input int p, input logic v);
        int n;
        bit blank;
        n = 0;
        blank = 1'b0;
        case (idx)
            5: begin n = a / 16; blank = LZ && (a < 16); end
            4: n = a % 16;
            3: if (v) begin n = b / 16; blank = LZ && (b < 16); end
               else begin n = p / 4096; blank = LZ && (p < 4096); end
            2: if (v) n = b % 16;
               else begin n = (p / 256) % 16; blank = LZ && (p < 256); end
            1: if (v) blank = 1'b1;
               else begin n = (p / 16) % 16; blank = LZ && (p < 16); end
            default: if (v) blank = 1'b1; else n = p % 16;
        endcase
        return blank ? 7'h7F : seg(4'(n));
    endfunction

    // Model: phase 0 idle, 1..8 multiply steps, 9 done pulse.
    logic [31:0] m_inq;
    logic        m_tog;
    int          m_a, m_b, m_prod, m_pend, m_phase;
    logic [6:0]  m_hex [6];
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_inq = '0; m_tog = 1'b0; m_a = 0; m_b = 0; m_prod = 0; m_phase = 0;
            for (int i = 0; i < 6; i++) m_hex[i] = 7'h7F;
            m_valid = 1'b1;
        end else begin
            for (int i = 0; i < 6; i++) m_hex[i] = digit(i, m_a, m_b, m_prod, m_inq[16]);
            if (m_phase == 0) begin
                if (m_inq[31] != m_tog) begin
                    m_tog = m_inq[31];
                    m_a = int'(m_inq[7:0]);
                    m_b = int'(m_inq[15:8]);
                    m_pend = m_a * m_b;
                    m_phase = 1;
                end
            end else if (m_phase < 9) begin
                if (m_phase == 8) m_prod = m_pend;
                m_phase++;
            end else begin
                m_phase = 0;
            end
            m_inq = word;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", 16'(busy), 16'(m_phase != 0));
            chk("done", 16'(done), 16'(m_phase == 9));
            chk("product", product, 16'(m_prod));
            chk("hex0", 16'(hex0), 16'(m_hex[0]));
            chk("hex1", 16'(hex1), 16'(m_hex[1]));
            chk("hex2", 16'(hex2), 16'(m_hex[2]));
            chk("hex3", 16'(hex3), 16'(m_hex[3]));
            chk("hex4", 16'(hex4), 16'(m_hex[4]));
            chk("hex5", 16'(hex5), 16'(m_hex[5]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        tog  = ~tog;
        word = {tog, 14'd0, view, b, a};
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        int k;
        k = 0;
        while (busy !== lvl && k < 40) begin
            tick(1);
            k++;
        end
        chk(name, 16'(busy), 16'(lvl));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int bc, dc;
        logic [7:0] ra, rb;

        tick(3);
        chk("rst_hex0", 16'(hex0), 16'h7F);
        chk("rst_hex5", 16'(hex5), 16'h7F);
        chk("rst_busy", 16'(busy), 16'h0);
        rst = 1'b0;
        tick(2);
        chk("post_rst_hex0", 16'(hex0), 16'h40);
        chk("post_rst_hex3", 16'(hex3), LZ ? 16'h7F : 16'h40);
        chk("post_rst_hex4", 16'(hex4), 16'h40);
        chk("post_rst_product", product, 16'h0000);

        send(8'h0C, 8'h0D);
        bc = 0; dc = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (busy) bc++;
            if (done) dc++;
        end
        chk("busy_cycles", 16'(bc), 16'd9);
        chk("done_pulses", 16'(dc), 16'd1);
        chk("p_0c0d", product, 16'h009C);
        chk("p_0c0d_hex1", 16'(hex1), 16'h10);
        chk("p_0c0d_hex0", 16'(hex0), 16'h46);
        chk("p_0c0d_hex3", 16'(hex3), LZ ? 16'h7F : 16'h40);
        chk("p_0c0d_hex2", 16'(hex2), LZ ? 16'h7F : 16'h40);

        send(8'hFF, 8'hFF);
        tick(20);
        chk("p_ffff", product, 16'hFE01);
        chk("p_ffff_hex3", 16'(hex3), 16'h0E);
        chk("p_ffff_hex2", 16'(hex2), 16'h06);
        chk("p_ffff_hex1", 16'(hex1), 16'h40);
        chk("p_ffff_hex0", 16'(hex0), 16'h79);

        send(8'd7, 8'd9);
        wait_busy(1'b1, "first_start");
        tick(3);
        send(8'd3, 8'd5);
        wait_busy(1'b0, "first_end");
        chk("first_result", product, 16'h003F);
        tick(1);
        chk("second_accept", 16'(busy), 16'h1);
        wait_busy(1'b0, "second_end");
        chk("second_result", product, 16'h000F);

        send(8'd2, 8'd3);
        wait_busy(1'b1, "dbl_start");
        tick(2);
        send(8'd4, 8'd4);
        tick(2);
        send(8'd6, 8'd6);
        wait_busy(1'b0, "dbl_end");
        bc = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (busy) bc++;
        end
        chk("dbl_absorbed", 16'(bc), 16'd0);
        chk("dbl_result", product, 16'h0006);

        send(8'h12, 8'h34);
        wait_busy(1'b1, "view_start");
        wait_busy(1'b0, "view_end");
        tick(2);
        view = 1'b1;
        word[16] = view;
        tick(2);
        chk("view_hex5", 16'(hex5), 16'h79);
        chk("view_hex4", 16'(hex4), 16'h24);
        chk("view_hex3", 16'(hex3), 16'h30);
        chk("view_hex2", 16'(hex2), 16'h19);
        chk("view_hex1", 16'(hex1), 16'h7F);
        chk("view_hex0", 16'(hex0), 16'h7F);
        view = 1'b0;
        word[16] = view;
        tick(2);

        if (tog) begin
            send(8'd1, 8'd1);
            wait_busy(1'b1, "pre_rst_start");
            wait_busy(1'b0, "pre_rst_end");
        end
        send(8'hA5, 8'h3C);
        wait_busy(1'b1, "rst_mul_start");
        tick(4);
        rst = 1'b1;
        tick(2);
        chk("rst_mul_product", product, 16'h0000);
        chk("rst_mul_busy", 16'(busy), 16'h0);
        rst = 1'b0;
        wait_busy(1'b1, "auto_start");
        wait_busy(1'b0, "auto_end");
        chk("auto_result", product, 16'(16'hA5 * 16'h3C));

        for (int i = 0; i < 60; i++) begin
            int r;
            r  = $urandom_range(0, 9);
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (r < 7) begin
                send(ra, rb);
            end else if (r < 9) begin
                view = ~view;
                word[16] = view;
            end else begin
                send(ra, rb);
                tick(2);
                send(rb, ra);
            end
            tick($urandom_range(0, 14));
        end
        tick(25);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
